// File: rtl/hyperbus_clk_ctrl.sv
// rtl/hyperbus_clk_ctrl.sv - power/activity sequencer for the HyperBus 4-phase clock generator
//
// Releases the clock-generator reset when the PHY requests phase clocks,
// waits a programmable warm-up, opens the phase-clock gates and acknowledges.
// On release it keeps clocks running for a programmable hold time, closes the
// gates, and only then re-asserts the generator reset.
//
// Optional feature macro: HYPERBUS_CLK_CTRL_STATS_EN
//   defined     : on_cycles_o counts cycles with clk_en_o=1 (saturating),
//                 stats_clr_i clears it (clear beats increment)
//   not defined : no counter, on_cycles_o tied to 0, stats_clr_i unused
//
// Ports:
//   clk_i        fast clock (same as the clock generator input)
//   rst_ni       asynchronous active-low reset
//   req_i        level request, PHY needs phase clocks
//   cfg_warmup_i warm-up cycles, sampled when leaving OFF
//   cfg_hold_i   idle hold cycles, sampled when leaving ON
//   stats_clr_i  clear the on-cycle counter
//   ack_o        phase clocks valid and running
//   gen_rst_no   active-low reset to the clock generator
//   clk_en_o     enable to the phase-clock gates
//   busy_o       controller not in OFF
//   state_o      current state encoding (debug)
//   on_cycles_o  number of cycles with clk_en_o=1

module hyperbus_clk_ctrl #(
  parameter int unsigned CntWidth  = 8,
  parameter int unsigned StatWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic [CntWidth-1:0]  cfg_warmup_i,
  input  logic [CntWidth-1:0]  cfg_hold_i,
  input  logic                 stats_clr_i,
  output logic                 ack_o,
  output logic                 gen_rst_no,
  output logic                 clk_en_o,
  output logic                 busy_o,
  output logic [2:0]           state_o,
  output logic [StatWidth-1:0] on_cycles_o
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_WAKE  = 3'd1,
    S_ON    = 3'd2,
    S_DRAIN = 3'd3,
    S_GATE  = 3'd4
  } state_e;

  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_OFF: begin
        if (req_i) begin
          state_d = S_WAKE;
          cnt_d   = cfg_warmup_i;
        end
      end
      S_WAKE: begin
        // Abort straight to GATE: gates were never opened, but the generator
        // reset is still released, so it goes through the normal shutdown.
        if (!req_i) begin
          state_d = S_GATE;
          cnt_d   = CntOne;
        end else if (cnt_q == '0) begin
          state_d = S_ON;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      S_ON: begin
        if (!req_i) begin
          state_d = S_DRAIN;
          cnt_d   = cfg_hold_i;
        end
      end
      S_DRAIN: begin
        // A returning request wins over hold expiry; clocks never stopped.
        if (req_i) begin
          state_d = S_ON;
        end else if (cnt_q == '0) begin
          state_d = S_GATE;
          cnt_d   = CntOne;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      S_GATE: begin
        // Two cycles with gates closed and generator still out of reset.
        if (cnt_q == '0) begin
          state_d = S_OFF;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered, decoded from the next state so they change on the
  // same edge as the state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_OFF;
      cnt_q      <= '0;
      ack_o      <= 1'b0;
      gen_rst_no <= 1'b0;
      clk_en_o   <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_o      <= (state_d == S_ON);
      gen_rst_no <= (state_d != S_OFF);
      clk_en_o   <= (state_d == S_ON) || (state_d == S_DRAIN);
      busy_o     <= (state_d != S_OFF);
    end
  end

  assign state_o = state_q;

`ifdef HYPERBUS_CLK_CTRL_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      on_cycles_o <= '0;
    end else if (stats_clr_i) begin
      on_cycles_o <= '0;
    end else if (clk_en_o && (on_cycles_o != '1)) begin
      on_cycles_o <= on_cycles_o + StatWidth'(1);
    end
  end
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr_i;
  assign on_cycles_o      = '0;
`endif

endmodule

// File: tb/tb_hyperbus_clk_ctrl.sv
// tb/tb_hyperbus_clk_ctrl.sv - self-checking bench for hyperbus_clk_ctrl

module tb_hyperbus_clk_ctrl;

  localparam int SW = 8;
  localparam int STAT_MAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic [7:0]    warmup = '0;
  logic [7:0]    hold = '0;
  logic          stats_clr = 1'b0;
  logic          ack, gen_rst_n, clk_en, busy;
  logic [2:0]    state;
  logic [SW-1:0] on_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  // reference: state number per the documented encoding, cycles remaining in
  // the current timed phase, and the on-cycle statistic
  int m_state = 0;
  int m_left  = 0;
  int m_stats = 0;

  hyperbus_clk_ctrl #(.CntWidth(8), .StatWidth(SW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .cfg_warmup_i(warmup),
    .cfg_hold_i  (hold),
    .stats_clr_i (stats_clr),
    .ack_o       (ack),
    .gen_rst_no  (gen_rst_n),
    .clk_en_o    (clk_en),
    .busy_o      (busy),
    .state_o     (state),
    .on_cycles_o (on_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_left  = 0;
    m_stats = 0;
  endtask

  // One clock edge of the reference. Phase lengths: WAKE = warmup+1 cycles,
  // DRAIN = hold+1 cycles, GATE = 2 cycles.
  task automatic model_edge();
    bit en_now;
    en_now = (m_state == 2) || (m_state == 3);
`ifdef HYPERBUS_CLK_CTRL_STATS_EN
    if (stats_clr) m_stats = 0;
    else if (en_now) m_stats = (m_stats >= STAT_MAX) ? STAT_MAX : m_stats + 1;
`endif
    case (m_state)
      0: if (req) begin m_state = 1; m_left = int'(warmup) + 1; end
      1: begin
        if (!req) begin
          m_state = 4; m_left = 2;
        end else begin
          m_left--;
          if (m_left == 0) m_state = 2;
        end
      end
      2: if (!req) begin m_state = 3; m_left = int'(hold) + 1; end
      3: begin
        if (req) m_state = 2;
        else begin
          m_left--;
          if (m_left == 0) begin m_state = 4; m_left = 2; end
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) m_state = 0;
      end
    endcase
  endtask

  task automatic compare_all();
    check("state", 32'(state), 32'(m_state));
    check("ack", 32'(ack), 32'(m_state == 2));
    check("gen_rst_no", 32'(gen_rst_n), 32'(m_state != 0));
    check("clk_en", 32'(clk_en), 32'((m_state == 2) || (m_state == 3)));
    check("busy", 32'(busy), 32'(m_state != 0));
    check("on_cycles", 32'(on_cycles), 32'(m_stats));
  endtask

  // inputs are held stable across the edge; outputs are checked 1ns after it
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic async_reset();
    @(posedge clk);
    if (rst_n) model_edge();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_gen_rst_no", 32'(gen_rst_n), 32'd0);
    check("rst_clk_en", 32'(clk_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_on_cycles", 32'(on_cycles), 32'd0);
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    // reset state
    cycles(2);
    check("reset_state", 32'(state), 32'd0);
    check("reset_gen_rst_no", 32'(gen_rst_n), 32'd0);
    rst_n = 1'b1;
    cycles(2);

    // warm-up of 3: generator reset released after 1 edge, ack on the 5th
    warmup = 8'd3;
    req = 1'b1;
    cycle();
    check("t1_gen_rst_1cyc", 32'(gen_rst_n), 32'd1);
    warmup = 8'd200;  // must not disturb the running count
    cycles(3);
    check("t1_ack_not_yet", 32'(ack), 32'd0);
    cycle();
    check("t1_ack_5cyc", 32'(ack), 32'd1);
    check("t1_clk_en_5cyc", 32'(clk_en), 32'd1);
    cycles(3);

    // hold of 4: ack drops at once, DRAIN 5 cycles, GATE 2 cycles
    hold = 8'd4;
    req = 1'b0;
    cycle();
    check("t2_ack_drop", 32'(ack), 32'd0);
    hold = 8'd0;
    cycles(4);
    check("t2_clk_en_still", 32'(clk_en), 32'd1);
    cycle();
    check("t2_clk_en_off", 32'(clk_en), 32'd0);
    check("t2_gen_rst_still", 32'(gen_rst_n), 32'd1);
    cycles(2);
    check("t2_gen_rst_off", 32'(gen_rst_n), 32'd0);
    check("t2_state_off", 32'(state), 32'd0);

    // request returning during DRAIN: straight back to ON
    warmup = 8'd0;
    req = 1'b1;
    cycles(3);
    hold = 8'd5;
    req = 1'b0;
    cycles(3);
    req = 1'b1;
    cycle();
    check("t3_state_on", 32'(state), 32'd2);
    check("t3_ack_back", 32'(ack), 32'd1);
    check("t3_gen_rst_kept", 32'(gen_rst_n), 32'd1);
    cycles(2);

    // hold of 0 with a request returning right at hold expiry
    hold = 8'd0;
    req = 1'b0;
    cycle();
    req = 1'b1;
    cycle();
    check("t3_prio_req", 32'(state), 32'd2);

    // abort during a warm-up of 10
    req = 1'b0;
    cycles(5);
    warmup = 8'd10;
    req = 1'b1;
    cycles(4);
    req = 1'b0;
    cycle();
    check("t4_gate", 32'(state), 32'd4);
    check("t4_clk_en_low", 32'(clk_en), 32'd0);
    cycle();
    check("t4_gate_2nd", 32'(state), 32'd4);
    cycle();
    check("t4_off", 32'(state), 32'd0);

    // asynchronous reset in ON
    warmup = 8'd1;
    req = 1'b1;
    cycles(5);
    async_reset();
    req = 1'b0;
    cycles(2);

    // statistics: 7 cycles of ON+DRAIN
    stats_clr = 1'b1;
    cycle();
    stats_clr = 1'b0;
    warmup = 8'd0;
    hold = 8'd2;
    req = 1'b1;
    cycles(5);
    req = 1'b0;
    cycles(4);
`ifdef HYPERBUS_CLK_CTRL_STATS_EN
    check("t5_on_7", 32'(on_cycles), 32'd7);
`else
    check("t5_on_0", 32'(on_cycles), 32'd0);
`endif
    cycles(4);
    req = 1'b1;
    cycles(4);
    stats_clr = 1'b1;
    cycle();
    check("t5_clr", 32'(on_cycles), 32'd0);
    stats_clr = 1'b0;
    cycles(STAT_MAX + 20);
`ifdef HYPERBUS_CLK_CTRL_STATS_EN
    check("t5_saturate", 32'(on_cycles), 32'(STAT_MAX));
`else
    check("t5_sat_off", 32'(on_cycles), 32'd0);
`endif

    // randomized traffic with cfg inputs changing every cycle
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) req = ~req;
      warmup = 8'($urandom_range(0, 6));
      hold = 8'($urandom_range(0, 6));
      stats_clr = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 799) == 0) async_reset();
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
